m72_sample_fetch: RTL and testbench



---
 rtl/m72_pkg.sv | 13 +
 rtl/m72_sample_fetch_if.sv | 26 ++
 rtl/m72_sample_fetch.sv | 121 ++++++++++++
 tb/tb_m72_sample_fetch.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/m72_pkg.sv
// Shared types and constants for the MCU sample-ROM fetch path.
package m72_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FETCH_START = 2'd1,
    WAIT        = 2'd2
  } fetch_state_t;

  // Mid-scale byte presented when the SDRAM never answers.
  localparam logic [7:0] SAMPLE_SILENCE = 8'h80;

endpackage

// File: rtl/m72_sample_fetch_if.sv
// MCU-side pointer/sample signals and SDRAM read-port signals of the sample fetcher.
// slave = the fetcher itself, master = the MCU/arbiter environment around it.
interface m72_sample_fetch_if #(
  parameter int SDR_AW = 25
);
  logic [1:0]        sample_addr_wr;
  logic [7:0]        sample_addr;
  logic              sample_inc;
  logic [7:0]        sample_rom_data;
  logic              sample_ready;
  logic              sdr_req;
  logic [SDR_AW-1:0] sdr_addr;
  logic              sdr_ack;
  logic [7:0]        sdr_data;
  logic              timeout_err;

  modport master (
    output sample_addr_wr, sample_addr, sample_inc, sdr_ack, sdr_data,
    input  sample_rom_data, sample_ready, sdr_req, sdr_addr, timeout_err
  );

  modport slave (
    input  sample_addr_wr, sample_addr, sample_inc, sdr_ack, sdr_data,
    output sample_rom_data, sample_ready, sdr_req, sdr_addr, timeout_err
  );
endinterface

// File: rtl/m72_sample_fetch.sv
// MCU sample pointer plus single-byte SDRAM fetch with tag cache and watchdog.
// sample_ready stalls the MCU while the byte under the pointer is not yet known.
module m72_sample_fetch
  import m72_pkg::*;
#(
  parameter int                SDR_AW   = 25,
  parameter logic [SDR_AW-1:0] ROM_BASE = '0,
  parameter int                TIMEOUT  = 255
) (
  input  logic               CLK_32M,
  input  logic               reset_n,
  m72_sample_fetch_if.slave  bus
);

  localparam int             CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int             WD_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0]  WD_LAST   = WD_LAST_I[CW-1:0];
  localparam bit             WD_EN     = (TIMEOUT != 0);

  fetch_state_t  state, state_nxt;
  logic [15:0]   pointer, ptr_nxt, tag, fetch_ptr;
  logic          tag_valid, pending, pend_nxt;
  logic          upd, moved, refetch, wd_hit;
  logic [CW-1:0] wd_cnt;
  logic          req_nxt, ready_nxt, load_ack, load_to;

  // Candidate pointer from this cycle's strobes and whether it invalidates the held/in-flight byte
  always_comb begin
    ptr_nxt = pointer;
    case (bus.sample_addr_wr)
      2'b11:   ptr_nxt = {bus.sample_addr, bus.sample_addr};
      2'b10:   ptr_nxt = {bus.sample_addr, pointer[7:0]};
      2'b01:   ptr_nxt = {pointer[15:8], bus.sample_addr};
      default: if (bus.sample_inc) ptr_nxt = pointer + 16'd1;
    endcase
    upd   = (bus.sample_addr_wr != 2'b00) || bus.sample_inc;
    moved = 1'b0;
    // Compare against whatever byte the pointer is supposed to end up at:
    // the cached tag when idle, the address being latched/fetched otherwise.
    if (upd) begin
      case (state)
        IDLE:        moved = !tag_valid || (ptr_nxt != tag);
        FETCH_START: moved = (ptr_nxt != pointer);
        default:     moved = (ptr_nxt != fetch_ptr);
      endcase
    end
    if (moved)                    pend_nxt = 1'b1;
    else if (state == FETCH_START) pend_nxt = 1'b0;
    else                          pend_nxt = pending;
    refetch = pending || moved;
    wd_hit  = WD_EN && (wd_cnt == WD_LAST);
  end

  // Next-state decision
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (pending) state_nxt = FETCH_START;
      FETCH_START: state_nxt = WAIT;
      WAIT: begin
        if (bus.sdr_ack)  state_nxt = refetch ? FETCH_START : IDLE;
        else if (wd_hit)  state_nxt = IDLE;
      end
      default:     state_nxt = FETCH_START;
    endcase
  end

  // Next values of the registered outputs and load strobes
  always_comb begin
    req_nxt  = 1'b0;
    load_ack = 1'b0;
    load_to  = 1'b0;
    case (state)
      FETCH_START: req_nxt = 1'b1;
      WAIT: begin
        if (bus.sdr_ack)  load_ack = !refetch;
        else if (wd_hit)  load_to  = 1'b1;
        else              req_nxt  = 1'b1;
      end
      default: ;
    endcase
    ready_nxt = (state_nxt == IDLE) && !pend_nxt;
  end

  // Control state, pointer and registered outputs
  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      state               <= FETCH_START;
      pointer             <= 16'h0000;
      pending             <= 1'b0;
      tag_valid           <= 1'b0;
      wd_cnt              <= '0;
      bus.sdr_req         <= 1'b0;
      bus.sample_ready    <= 1'b0;
      bus.timeout_err     <= 1'b0;
      bus.sample_rom_data <= SAMPLE_SILENCE;
    end else begin
      state            <= state_nxt;
      pointer          <= ptr_nxt;
      pending          <= pend_nxt;
      bus.sdr_req      <= req_nxt;
      bus.sample_ready <= ready_nxt;
      if (state == FETCH_START) wd_cnt <= '0;
      else if (state == WAIT)   wd_cnt <= wd_cnt + 1'b1;
      if (load_ack)     bus.sample_rom_data <= bus.sdr_data;
      else if (load_to) bus.sample_rom_data <= SAMPLE_SILENCE;
      if (load_ack || load_to) tag_valid <= 1'b1;
      if (load_to) bus.timeout_err <= 1'b1;
    end
  end

  // Fetch address and tag bookkeeping; validity is carried by the control registers
  always_ff @(posedge CLK_32M) begin
    if (state == FETCH_START) begin
      bus.sdr_addr <= ROM_BASE + SDR_AW'(pointer);
      fetch_ptr    <= pointer;
    end
    if (load_ack || load_to) tag <= fetch_ptr;
  end

endmodule

// File: tb/tb_m72_sample_fetch.sv
// Directed bench for m72_sample_fetch with a behavioural pointer/ROM model and SDRAM responder.
module tb_m72_sample_fetch;

  localparam int          SDR_AW = 25;
  localparam logic [24:0] BASE   = 25'h0123000;
  localparam int          TMO    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  m72_sample_fetch_if #(.SDR_AW(SDR_AW)) bus ();

  m72_sample_fetch #(.SDR_AW(SDR_AW), .ROM_BASE(BASE), .TIMEOUT(TMO)) dut (
    .CLK_32M (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          armed = 1'b0;
  bit          never_ack = 1'b0;
  int          ack_delay = 5;
  int          fetch_cnt = 0;
  int          ack_cycle = -1;
  bit          exp_to = 1'b0;
  logic [24:0] last_fetch_addr = '0;
  logic [15:0] mptr;
  logic        moved_last;

  // Sample ROM image: byte 0 is 0x12, everything else a simple hash.
  function automatic logic [7:0] rom(input logic [15:0] p);
    if (p == 16'h0000) return 8'h12;
    return p[7:0] ^ p[15:8] ^ 8'h5A;
  endfunction

  // Pointer after one cycle of strobes: writes win over increment, 11 loads both bytes.
  function automatic logic [15:0] model_next(input logic [15:0] p, input logic [1:0] wr,
                                             input logic [7:0] a, input logic inc);
    if (wr == 2'b11) return {a, a};
    if (wr == 2'b01) return {p[15:8], a};
    if (wr == 2'b10) return {a, p[7:0]};
    if (inc)         return p + 16'd1;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mptr       <= 16'h0000;
      moved_last <= 1'b0;
    end else begin
      mptr       <= model_next(mptr, bus.sample_addr_wr, bus.sample_addr, bus.sample_inc);
      moved_last <= (model_next(mptr, bus.sample_addr_wr, bus.sample_addr, bus.sample_inc) != mptr);
    end
  end

  // Per-cycle compare against the model, plus the SDRAM read-port responder.
  initial begin : mon
    int          cnt;
    bit          busy;
    bit          arm;
    logic [24:0] lat;
    cnt = 0; busy = 1'b0; arm = 1'b0; lat = '0;
    bus.sdr_ack  = 1'b0;
    bus.sdr_data = 8'h00;
    forever begin
      @(negedge clk);
      bus.sdr_ack = 1'b0;
      if (!rst_n || !armed) begin
        busy = 1'b0; cnt = 0; arm = 1'b0; exp_to = 1'b0;
      end else begin
        if (arm) begin exp_to = 1'b1; arm = 1'b0; end
        chk("timeout_err", 32'(bus.timeout_err), 32'(exp_to));
        if (bus.sample_ready) begin
          chk("ready_data", 32'(bus.sample_rom_data), 32'(never_ack ? 8'h80 : rom(mptr)));
          chk("ready_after_move", 32'(moved_last), 32'd0);
          chk("ready_with_req", 32'(bus.sdr_req), 32'd0);
        end
        if (bus.sdr_req) begin
          if (!busy) begin
            busy = 1'b1; cnt = 0; lat = bus.sdr_addr;
            fetch_cnt++;
            last_fetch_addr = bus.sdr_addr;
            if (!moved_last) chk("req_addr", 32'(bus.sdr_addr), 32'(BASE + {9'd0, mptr}));
          end else begin
            chk("addr_stable", 32'(bus.sdr_addr), 32'(lat));
          end
          cnt++;
          if (!never_ack && cnt == ack_delay) begin
            bus.sdr_ack  = 1'b1;
            bus.sdr_data = rom(16'(bus.sdr_addr - BASE));
            ack_cycle    = cyc;
            busy         = 1'b0;
          end else if (cnt == TMO) begin
            arm = 1'b1;
          end
        end else begin
          busy = 1'b0;
        end
      end
    end
  end

  task automatic pulse(input logic [1:0] wr, input logic [7:0] a, input logic inc);
    bus.sample_addr_wr = wr;
    bus.sample_addr    = a;
    bus.sample_inc     = inc;
    @(negedge clk);
    bus.sample_addr_wr = 2'b00;
    bus.sample_addr    = 8'h00;
    bus.sample_inc     = 1'b0;
  endtask

  task automatic wait_req(input string name, input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.sdr_req) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: sdr_req not seen within %0d cycles", name, max);
    end
  endtask

  task automatic wait_ready(input string name, input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.sample_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: sample_ready not seen within %0d cycles", name, max);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected end of stimulus");
    $fatal(1);
  end

  initial begin
    int f0;
    int n;
    bus.sample_addr_wr = 2'b00;
    bus.sample_addr    = 8'h00;
    bus.sample_inc     = 1'b0;
    #2 rst_n = 1'b0;
    armed = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.sample_ready), 32'd0);
    chk("rst_req",   32'(bus.sdr_req), 32'd0);
    chk("rst_data",  32'(bus.sample_rom_data), 32'h80);
    chk("rst_to",    32'(bus.timeout_err), 32'd0);

    // Test 1: fetch of byte 0 after reset release, ack after 5 cycles
    ack_delay = 5;
    rst_n = 1'b1;
    wait_req("t1_req", 4);
    chk("t1_addr", 32'(bus.sdr_addr), 32'h0123000);
    wait_ready("t1_ready", 30);
    chk("t1_latency", 32'(cyc), 32'(ack_cycle + 1));
    chk("t1_data", 32'(bus.sample_rom_data), 32'h12);

    // Test 2: byte-wise pointer load to 0x1234
    f0 = fetch_cnt;
    pulse(2'b01, 8'h34, 1'b0);
    pulse(2'b10, 8'h12, 1'b0);
    wait_ready("t2_ready", 60);
    chk("t2_addr", 32'(last_fetch_addr), 32'h0124234);
    chk("t2_nfetch_le2", 32'((fetch_cnt - f0) <= 2), 32'd1);
    chk("t2_data", 32'(bus.sample_rom_data), 32'h7C);

    // Test 3: increment wraps 0xFFFF -> 0x0000
    pulse(2'b11, 8'hFF, 1'b0);
    wait_ready("t3_ready_ffff", 30);
    chk("t3_data_ffff", 32'(bus.sample_rom_data), 32'h5A);
    pulse(2'b00, 8'h00, 1'b1);
    chk("t3_ready_low", 32'(bus.sample_ready), 32'd0);
    wait_req("t3_req", 5);
    chk("t3_addr", 32'(bus.sdr_addr), 32'h0123000);
    wait_ready("t3_ready", 30);
    chk("t3_data", 32'(bus.sample_rom_data), 32'h12);

    // Test 4: increment while the fetch is in flight forces a refetch
    ack_delay = 10;
    f0 = fetch_cnt;
    pulse(2'b10, 8'h01, 1'b0);
    wait_req("t4_req", 5);
    repeat (3) @(negedge clk);
    pulse(2'b00, 8'h00, 1'b1);
    wait_ready("t4_ready", 80);
    chk("t4_nfetch", 32'(fetch_cnt - f0), 32'd2);
    chk("t4_addr", 32'(last_fetch_addr), 32'h0123101);
    chk("t4_data", 32'(bus.sample_rom_data), 32'h5A);

    // Test 5: wr=11 with simultaneous inc loads 0x5656, no increment
    ack_delay = 4;
    pulse(2'b11, 8'h56, 1'b1);
    wait_ready("t5_ready", 30);
    chk("t5_addr", 32'(last_fetch_addr), 32'h0128656);
    chk("t5_data", 32'(bus.sample_rom_data), 32'h5A);

    // Test 6: no ack -> watchdog after 16 WAIT cycles
    never_ack = 1'b1;
    pulse(2'b01, 8'h77, 1'b0);
    wait_req("t6_req", 5);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.sdr_req) break;
      n++;
    end
    chk("t6_req_cycles", 32'(n), 32'd16);
    chk("t6_ready", 32'(bus.sample_ready), 32'd1);
    chk("t6_data", 32'(bus.sample_rom_data), 32'h80);
    chk("t6_to", 32'(bus.timeout_err), 32'd1);

    // Test 7: flag stays sticky; reset mid-fetch drops sdr_req at once
    pulse(2'b00, 8'h00, 1'b1);
    wait_req("t7_req", 5);
    repeat (2) @(negedge clk);
    chk("t7_to_sticky", 32'(bus.timeout_err), 32'd1);
    chk("t7_req_mid", 32'(bus.sdr_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_req", 32'(bus.sdr_req), 32'd0);
    chk("t7_rst_to", 32'(bus.timeout_err), 32'd0);
    chk("t7_rst_ready", 32'(bus.sample_ready), 32'd0);
    chk("t7_rst_data", 32'(bus.sample_rom_data), 32'h80);
    @(negedge clk);
    never_ack = 1'b0;
    ack_delay = 3;
    rst_n = 1'b1;
    wait_ready("t7_ready", 20);
    chk("t7_data", 32'(bus.sample_rom_data), 32'h12);
    chk("t7_to_clear", 32'(bus.timeout_err), 32'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
